// File: rtl/bcd_digit_feeder.sv
// Sequential shift-and-add-3 binary-to-BCD converter for a 6-digit display.
// Outputs are registered and only change on the done pulse, so the display scan always reads a whole value.

module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   always_comb begin
      dout = din;
      if (din >= 4'd5) dout = din + 4'd3;
   end
endmodule

module bcd_digit_feeder #(
   parameter int          BIN_WIDTH = 20,
   parameter bit          LZ_BLANK  = 1'b1,
   parameter int unsigned MAX_VALUE = 999999
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIN_WIDTH-1:0] bin_in,
   input  logic                 valid_in,
   output logic                 ready,
   output logic [23:0]          bcd_out,
   output logic [5:0]           blank,
   output logic                 overflow,
   output logic                 done
);
   localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
   localparam logic [5:0] BLANK_RST = LZ_BLANK ? 6'b111110 : 6'b000000;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

   state_t               state_q, state_d;
   logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
   logic [23:0]          acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ovf_pend_q, ovf_pend_d;
   logic [23:0]          bcd_q, bcd_d;
   logic [5:0]           blank_q, blank_d;
   logic                 ovf_q, ovf_d;
   logic                 done_q, done_d;

   logic [23:0]          acc_adj;
   logic [23:0]          final_bcd;
   logic [5:0]           final_blank;
   logic                 zero_run;
   logic                 in_ovf;
   logic                 carry_unused;

   // One add-3 corrector per digit, applied before every shift
   for (genvar g = 0; g < 6; g++) begin : g_dig
      bcd_add3 u_add3 (.din(acc_q[4*g +: 4]), .dout(acc_adj[4*g +: 4]));
   end

   // Carry out of digit5 only occurs above MAX_VALUE, which saturates anyway
   assign carry_unused = acc_adj[23];
   assign in_ovf       = 33'(bin_in) > 33'(MAX_VALUE);
   assign final_bcd    = ovf_pend_q ? 24'h999999 : acc_q;

   always_comb begin
      final_blank = '0;
      zero_run    = 1'b1;
      for (int i = 5; i >= 1; i--) begin
         zero_run       = zero_run & (final_bcd[4*i +: 4] == 4'd0);
         final_blank[i] = LZ_BLANK & zero_run;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      bcd_d      = bcd_q;
      blank_d    = blank_q;
      ovf_d      = ovf_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               shreg_d    = bin_in;
               acc_d      = '0;
               cnt_d      = CW'(BIN_WIDTH - 1);
               ovf_pend_d = in_ovf;
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            acc_d   = {acc_adj[22:0], shreg_q[BIN_WIDTH-1]};
            shreg_d = shreg_q << 1;
            if (cnt_q == '0) state_d = S_FINISH;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_FINISH: begin
            bcd_d   = final_bcd;
            blank_d = final_blank;
            ovf_d   = ovf_pend_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         shreg_q    <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         bcd_q      <= '0;
         blank_q    <= BLANK_RST;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         bcd_q      <= bcd_d;
         blank_q    <= blank_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   assign ready    = (state_q == S_IDLE);
   assign bcd_out  = bcd_q;
   assign blank    = blank_q;
   assign overflow = ovf_q;
   assign done     = done_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Scoreboard bench for bcd_digit_feeder: stimulus pushes hand-computed results, a monitor checks each done pulse.

module tb_bcd_digit_feeder;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [19:0] bin_in = '0;
   logic        valid_in = 1'b0;
   logic        ready;
   logic [23:0] bcd_out;
   logic [5:0]  blank;
   logic        overflow;
   logic        done;

   bcd_digit_feeder dut (
      .clk(clk), .reset(reset), .bin_in(bin_in), .valid_in(valid_in),
      .ready(ready), .bcd_out(bcd_out), .blank(blank),
      .overflow(overflow), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] bcd;
      logic [5:0]  blk;
      logic        ovf;
      int          acc;
      int          gap;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   last_done = -1000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bcd_out",  32'(bcd_out),  32'(e.bcd));
            chk("blank",    32'(blank),    32'(e.blk));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("latency",  32'(cyc - e.acc), 32'd21);
            chk("ready_with_done", 32'(ready), 32'd1);
            if (e.gap != 0) chk("done_gap", 32'(cyc - last_done), 32'(e.gap));
         end
         last_done = cyc;
      end
   end

   task automatic convert(input logic [19:0] v, input logic [23:0] eb, input logic [5:0] ebl,
                          input logic eo, input bit push, input bit hold, input int gap);
      int t;
      t = 0;
      @(negedge clk);
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         n_cmp++; n_err++;
         $display("FAIL ready_timeout: got ready=0 expected ready=1 within 100 cycles");
      end
      bin_in   = v;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      if (push) sb.push_back('{eb, ebl, eo, cyc, gap});
      if (!hold) valid_in = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_bcd",   32'(bcd_out),  32'h0);
      chk("rst_blank", 32'(blank),    32'h3E);
      chk("rst_ovf",   32'(overflow), 32'h0);
      chk("rst_done",  32'(done),     32'h0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 32'h1);

      convert(20'd0, 24'h000000, 6'b111110, 1'b0, 1, 0, 0);
      drain();

      convert(20'd123456, 24'h123456, 6'b000000, 1'b0, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("busy_ready", 32'(ready), 32'h0);
      end
      drain();

      convert(20'd1000, 24'h001000, 6'b110000, 1'b0, 1, 0, 0);
      convert(20'd7,    24'h000007, 6'b111110, 1'b0, 1, 0, 0);
      convert(20'd999999,  24'h999999, 6'b000000, 1'b0, 1, 0, 0);
      convert(20'd1000000, 24'h999999, 6'b000000, 1'b1, 1, 0, 0);
      convert(20'hFFFFF,   24'h999999, 6'b000000, 1'b1, 1, 0, 0);
      drain();

      // Abort mid-conversion: outputs drop to reset values at once, no done follows
      convert(20'd654321, 24'h0, 6'b0, 1'b0, 0, 0, 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_bcd",   32'(bcd_out),  32'h0);
      chk("abort_blank", 32'(blank),    32'h3E);
      chk("abort_ovf",   32'(overflow), 32'h0);
      chk("abort_done",  32'(done),     32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(ready), 32'h1);
      repeat (30) @(negedge clk);

      // valid_in toggling while busy must be ignored
      convert(20'd654321, 24'h654321, 6'b000000, 1'b0, 1, 0, 0);
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         valid_in = i[0];
         bin_in   = 20'(111 * i);
      end
      @(negedge clk);
      valid_in = 1'b0;
      drain();

      // Back-to-back with valid_in held high
      convert(20'd5,  24'h000005, 6'b111110, 1'b0, 1, 1, 0);
      convert(20'd50, 24'h000050, 6'b111100, 1'b0, 1, 0, 22);
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
